// File: rtl/lmsm_pkg.sv
// Shared types and default widths for the LM/SM memory-stage sequencer.
package lmsm_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int NREGS     = 8;
  localparam int IDX_W     = 3;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lmsm_prienc.sv
// Lowest-set-bit priority encoder over the remaining register mask.
// last is high when exactly one bit is set (the transfer being issued is the final one).
module lmsm_prienc
  import lmsm_pkg::*;
#(
  parameter int W  = NREGS,
  parameter int IW = IDX_W
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          last
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign last = (mask != '0) && ((mask & (mask - W'(1))) == '0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: one data-memory transfer per cycle, walking the register mask low to high.
// Optional LMSM_ADDR_CHECK_EN suppresses transfers at or above MEM_DEPTH and sets a sticky err.
module lm_sm_sequencer
  import lmsm_pkg::*;
#(
  parameter int DATA_W    = lmsm_pkg::DATA_W,
  parameter int ADDR_W    = lmsm_pkg::ADDR_W,
  parameter int NREGS     = lmsm_pkg::NREGS,
  parameter int MEM_DEPTH = lmsm_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_n,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  rf_rd_idx,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_idx,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE; busy covers RUN and DONE,
  // and done pulses for exactly the one DONE cycle. No back-pressure from memory or the RF.

  state_e             state_q, state_d;
  logic               is_store_q, is_store_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [NREGS-1:0]   rem_mask_q, rem_mask_d;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               xfer_ok;
  logic               err_d;

  lmsm_prienc #(
    .W  (NREGS),
    .IW (IDX_W)
  ) u_prienc (
    .mask (rem_mask_q),
    .idx  (idx),
    .last (last)
  );

`ifdef LMSM_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
  logic err_q;

  assign xfer_ok = ({1'b0, cur_addr_q} < DEPTH_LIM);
  assign err     = err_q;
`else
  assign xfer_ok = 1'b1;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    cur_addr_d  = cur_addr_q;
    rem_mask_d  = rem_mask_q;
    err_d       = err;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_write_n = 1'b1;
    rf_rd_idx   = '0;
    rf_wr_en    = 1'b0;
    rf_wr_idx   = '0;
    rf_wr_data  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          cur_addr_d = base_addr;
          rem_mask_d = reg_mask;
          state_d    = (reg_mask != '0) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        mem_addr = cur_addr_q;
        if (is_store_q) begin
          rf_rd_idx   = idx;
          mem_wdata   = rf_rd_data;
          mem_write_n = ~xfer_ok;
        end else begin
          rf_wr_en   = xfer_ok;
          rf_wr_idx  = idx;
          rf_wr_data = mem_rdata;
        end
        // A suppressed transfer still consumes its mask bit and advances the address.
        rem_mask_d = rem_mask_q & (rem_mask_q - NREGS'(1));
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        err_d      = err | ~xfer_ok;
        if (last) state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      cur_addr_q <= '0;
      rem_mask_q <= '0;
`ifdef LMSM_ADDR_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      cur_addr_q <= cur_addr_d;
      rem_mask_q <= rem_mask_d;
`ifdef LMSM_ADDR_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Initiator-side controller for the data_memory port: drives the read address, write address, write data and active-low write strobe.
- Executes LM (load multiple) and SM (store multiple) instructions by walking an 8-bit register mask, one memory transfer per cycle.
- Sits in the pipeline's memory stage. It stalls upstream stages while busy and talks directly to the register file read/write ports.

Parameters:
- DATA_W, 16, data and register width
- ADDR_W, 16, memory address width
- NREGS, 8, register count (= mask width)
- MEM_DEPTH, 256, implemented data-memory words (used only by the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_store  in  1  1 = SM, 0 = LM; latched with start
- base_addr  in  ADDR_W  first transfer address; latched with start
- reg_mask  in  NREGS  bit i set = transfer register Ri; latched with start
- mem_addr  out  ADDR_W  drives both readAdd and writeAdd of data memory
- mem_wdata  out  DATA_W  store data to memory
- mem_write_n  out  1  active-low write strobe (0 = write this cycle)
- mem_rdata  in  DATA_W  combinational (asynchronous) read data from memory
- rf_rd_idx  out  3  register-file read index (store source)
- rf_rd_data  in  DATA_W  combinational register-file read data
- rf_wr_en  out  1  register-file write enable (load)
- rf_wr_idx  out  3  register-file write index
- rf_wr_data  out  DATA_W  register-file write data
- busy  out  1  high in RUN and DONE; used as pipeline stall
- done  out  1  one-cycle completion pulse
- err  out  1  sticky range-error flag (tied 0 unless LMSM_ADDR_CHECK_EN)

Behaviour:
- States are IDLE, RUN and DONE, held in registers cleared by reset.
- Reset values: state = IDLE; busy = 0, done = 0, rf_wr_en = 0, err = 0; mem_write_n = 1; mem_addr, mem_wdata, rf_rd_idx, rf_wr_idx, rf_wr_data all = 0.
- Reset takes effect immediately (asynchronous), including in the middle of an operation. mem_write_n = 1 and rf_wr_en = 0 the instant reset asserts, and no partial transfer completes.
- IDLE:
  - On start = 1, latch is_store, base_addr into cur_addr, and reg_mask into rem_mask.
  - Next state is RUN if reg_mask != 0, otherwise DONE.
  - All strobes are inactive in IDLE.
- RUN, one transfer per cycle:
  - idx = lowest set bit of rem_mask; mem_addr = cur_addr.
  - SM: rf_rd_idx = idx, mem_wdata = rf_rd_data, mem_write_n = 0.
  - LM: rf_wr_en = 1, rf_wr_idx = idx, rf_wr_data = mem_rdata.
  - These outputs are combinational from state/rem_mask/cur_addr. On the clock edge: clear bit idx in rem_mask; cur_addr <= cur_addr + 1.
- RUN exit: when the bit being cleared is the last set bit, next state = DONE.
- DONE: done = 1 for exactly one cycle, no strobes, then IDLE.
- Latency: a mask with N set bits gives N transfer cycles immediately after the start cycle. done is asserted in cycle N+1. A mask of 0 gives done in cycle 1.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF + 1 wraps to 0x0000.
- start while busy = 1 is ignored; no queuing.
- start and reset asserted together: reset wins.
- Register read-after-write inside one LM is not possible, because each index is visited once.

Optional Feature:
- Macro: LMSM_ADDR_CHECK_EN.
- With the macro defined:
  - Any RUN transfer with cur_addr >= MEM_DEPTH is suppressed: mem_write_n stays 1 and rf_wr_en stays 0.
  - The mask bit is still consumed and the address still increments.
  - err is set and stays set until reset.
- Without the macro: no checking; err is tied to 0.

Decomposition:
- Package lmsm_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - widths DATA_W, ADDR_W, NREGS;
  - the index width constant (3).
- One sub-module: lmsm_prienc, an 8-bit lowest-set-bit priority encoder producing a 3-bit index plus a "last bit" flag (popcount == 1).

Test Plan:
- SM, mask 0x06, base 0x0010, R1 = 0x1111, R2 = 0x2222 -> cycle 1: write 0x1111 @ 0x0010; cycle 2: write 0x2222 @ 0x0011; done in cycle 3; busy high cycles 1-3.
- LM, mask 0x81, base 0x0040, mem[0x40] = 0xABCD, mem[0x41] = 0x1234 -> R0 = 0xABCD, then R7 = 0x1234; mem_write_n stays 1 throughout.
- Mask 0x00 -> no memory or register-file strobe; done in cycle 1; IDLE in cycle 2.
- SM, mask 0x03, base 0xFFFF -> writes at 0xFFFF, then 0x0000 (wrap).
- LM, mask 0xFF; assert reset in cycle 3 -> writes stop immediately; only R0-R1 written; all outputs at reset values; a new start after release works.
- LMSM_ADDR_CHECK_EN, SM, mask 0x03, base 0x00FF -> write @ 0x00FF; second transfer @ 0x0100 suppressed; err = 1; a start pulse during busy is ignored.
